// File: rtl/vdp_cpu_port.sv
// CPU-side host port of the nouveau-vdp99: decodes TMS9918-style data/control
// accesses into VRAM requests, register writes and status reads.
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              cpu_mode,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              reg_we,
  output logic [2:0]        reg_num,
  output logic [7:0]        reg_data,
  input  logic [7:0]        status,
  output logic              status_rd
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        latch;
  logic [7:0]        readahead;
  logic              second;
  logic              idle;
  logic              data_wr, data_rd, ctrl_wr, ctrl_rd;
  logic              addr_load, addr_inc;

  assign idle      = (state == IDLE);
  assign vram_addr = addr;

  // Data-port strobes are dropped while a VRAM access is outstanding.
  assign data_wr   = cpu_wr & ~cpu_mode & idle;
  assign data_rd   = cpu_rd & ~cpu_mode & idle;
  assign ctrl_wr   = cpu_wr & cpu_mode;
  assign ctrl_rd   = cpu_rd & cpu_mode;
  assign addr_load = ctrl_wr & second & ~cpu_din[7] & idle;

  always_ff @(posedge wr_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    vram_req   = 1'b0;
    vram_we    = 1'b0;
    busy       = 1'b1;
    addr_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (data_wr)
          state_next = WR_REQ;
        else if (data_rd || (addr_load && !cpu_din[6]))
          state_next = RD_REQ;
      end
      WR_REQ: begin
        vram_req = 1'b1;
        vram_we  = 1'b1;
        if (vram_ack) begin
          addr_inc   = 1'b1;
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        vram_req = 1'b1;
        if (vram_ack) begin
          addr_inc   = 1'b1;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      addr       <= '0;
      latch      <= '0;
      second     <= 1'b0;
      cpu_dout   <= '0;
      readahead  <= '0;
      vram_wdata <= '0;
      reg_we     <= 1'b0;
      reg_num    <= '0;
      reg_data   <= '0;
      status_rd  <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      status_rd <= 1'b0;

      if (ctrl_wr) begin
        if (!second) begin
          latch  <= cpu_din;
          second <= 1'b1;
        end else begin
          second <= 1'b0;
          if (cpu_din[7]) begin
            reg_we   <= 1'b1;
            reg_num  <= cpu_din[2:0];
            reg_data <= latch;
          end else if (addr_load) begin
            addr <= ADDR_W'({cpu_din[5:0], latch});
          end
        end
      end

      if (ctrl_rd) begin
        cpu_dout  <= status;
        status_rd <= 1'b1;
        second    <= 1'b0;
      end

      if (data_wr) begin
        second     <= 1'b0;
        vram_wdata <= cpu_din;
        readahead  <= cpu_din;
      end

      if (data_rd) begin
        second   <= 1'b0;
        cpu_dout <= readahead;
      end

      // addr_inc only occurs outside IDLE, so it never collides with addr_load.
      if (addr_inc) addr <= addr + ADDR_W'(1);

      if (state == RD_WAIT) readahead <= vram_rdata;
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a registered-RAM VRAM model and an
// ack generator whose grant can be held off.
module tb_vdp_cpu_port;

  logic        wr_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_mode = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rdata = '0;
  logic        reg_we;
  logic [2:0]  reg_num;
  logic [7:0]  reg_data;
  logic [7:0]  status = '0;
  logic        status_rd;

  logic        ack_en = 1'b1;
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [0:16383];
  int          req_age = 0;
  int          wr_cnt = 0;
  int          reg_cnt = 0;
  int          req_cycles = 0;
  int          checks = 0;
  int          failures = 0;
  int          snap_a, snap_b;

  vdp_cpu_port #(.ADDR_W(14)) dut (
    .wr_clk(wr_clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_mode(cpu_mode), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data),
    .status(status), .status_rd(status_rd)
  );

  always #5 wr_clk = ~wr_clk;

  // Grant arrives in the second cycle of a request when enabled.
  always @(negedge wr_clk) begin
    #1;
    if (vram_req) req_age = req_age + 1;
    else          req_age = 0;
    vram_ack = ack_en && vram_req && (req_age > 1);
  end

  always @(posedge wr_clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (vram_req && vram_ack) begin
      if (vram_we) begin
        mem[vram_addr] <= vram_wdata;
        wr_cnt         <= wr_cnt + 1;
      end else begin
        vram_rdata <= mem[vram_addr];
      end
    end
    if (reg_we)   reg_cnt    <= reg_cnt + 1;
    if (vram_req) req_cycles <= req_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) @(negedge wr_clk);
  endtask

  task automatic access(input logic wr, input logic mode, input logic [7:0] d);
    cpu_wr   = wr;
    cpu_rd   = ~wr;
    cpu_mode = mode;
    cpu_din  = d;
    @(negedge wr_clk);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge wr_clk);
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    vram_req, 0);
    check_eq({tag, "_we"},     vram_we, 0);
    check_eq({tag, "_busy"},   busy, 0);
    check_eq({tag, "_addr"},   vram_addr, 0);
    check_eq({tag, "_wdata"},  vram_wdata, 0);
    check_eq({tag, "_dout"},   cpu_dout, 0);
    check_eq({tag, "_reg_we"}, reg_we, 0);
    check_eq({tag, "_st_rd"},  status_rd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycle(3);
    reset = 1'b0;
    check_reset_outputs("rst0");

    // Address setup 0x1234 then two sequential writes.
    access(1, 1, 8'h34);
    access(1, 1, 8'h52);
    check_eq("setup_addr", vram_addr, 14'h1234);
    access(1, 0, 8'hAA);
    check_eq("wr1_req", vram_req, 1);
    check_eq("wr1_we", vram_we, 1);
    check_eq("wr1_addr", vram_addr, 14'h1234);
    check_eq("wr1_wdata", vram_wdata, 8'hAA);
    cycle(1);
    check_eq("wr1_busy_ack", busy, 1);
    cycle(1);
    check_eq("wr1_busy_clr", busy, 0);
    check_eq("wr1_addr_inc", vram_addr, 14'h1235);
    check_eq("wr1_mem", mem[14'h1234], 8'hAA);
    access(1, 0, 8'hBB);
    cycle(2);
    check_eq("wr2_busy_clr", busy, 0);
    check_eq("wr2_addr_inc", vram_addr, 14'h1236);
    check_eq("wr2_mem", mem[14'h1235], 8'hBB);

    // Register write: R7 <= 0x81.
    snap_a = reg_cnt;
    snap_b = req_cycles;
    access(1, 1, 8'h81);
    access(1, 1, 8'h87);
    check_eq("reg_we", reg_we, 1);
    check_eq("reg_num", reg_num, 7);
    check_eq("reg_data", reg_data, 8'h81);
    cycle(1);
    check_eq("reg_we_drop", reg_we, 0);
    check_eq("reg_pulses", reg_cnt - snap_a, 1);
    check_eq("reg_no_req", req_cycles - snap_b, 0);
    check_eq("reg_addr_kept", vram_addr, 14'h1236);

    // Read setup at 0x0100 and read-ahead stream.
    pl_we = 1'b1; pl_addr = 14'h0100; pl_data = 8'h11;
    cycle(1);
    pl_addr = 14'h0101; pl_data = 8'h22;
    cycle(1);
    pl_we = 1'b0;
    access(1, 1, 8'h00);
    access(1, 1, 8'h01);
    check_eq("rs_req", vram_req, 1);
    check_eq("rs_we", vram_we, 0);
    check_eq("rs_addr", vram_addr, 14'h0100);
    wait_idle("rs_idle");
    check_eq("rs_addr_inc", vram_addr, 14'h0101);
    access(0, 0, 8'h00);
    check_eq("rd1_dout", cpu_dout, 8'h11);
    wait_idle("rd1_idle");
    access(0, 0, 8'h00);
    check_eq("rd2_dout", cpu_dout, 8'h22);
    wait_idle("rd2_idle");
    check_eq("rd_addr_end", vram_addr, 14'h0103);

    // Control read resets the byte toggle.
    access(1, 1, 8'h55);
    status = 8'h80;
    access(0, 1, 8'h00);
    check_eq("st_dout", cpu_dout, 8'h80);
    check_eq("st_rd_pulse", status_rd, 1);
    cycle(1);
    check_eq("st_rd_drop", status_rd, 0);
    access(1, 1, 8'h00);
    access(1, 1, 8'h41);
    check_eq("tog_addr", vram_addr, 14'h0100);
    check_eq("tog_busy", busy, 0);

    // Wrap at 0x3FFF, then busy with ack held off.
    access(1, 1, 8'hFF);
    access(1, 1, 8'h7F);
    check_eq("wrap_setup", vram_addr, 14'h3FFF);
    access(1, 0, 8'h5A);
    wait_idle("wrap_idle");
    check_eq("wrap_addr", vram_addr, 14'h0000);
    check_eq("wrap_mem", mem[14'h3FFF], 8'h5A);
    snap_a = wr_cnt;
    ack_en = 1'b0;
    access(1, 0, 8'hC3);
    check_eq("hold_req", vram_req, 1);
    access(1, 0, 8'hE7);
    access(0, 0, 8'h00);
    cycle(3);
    check_eq("hold_req5", vram_req, 1);
    check_eq("hold_wdata", vram_wdata, 8'hC3);
    check_eq("hold_addr", vram_addr, 14'h0000);
    check_eq("hold_dout", cpu_dout, 8'h80);
    ack_en = 1'b1;
    wait_idle("hold_idle");
    cycle(2);
    check_eq("hold_busy_after", busy, 0);
    check_eq("hold_addr_end", vram_addr, 14'h0001);
    check_eq("hold_wr_count", wr_cnt - snap_a, 1);
    check_eq("hold_mem", mem[14'h0000], 8'hC3);

    // Reset while a write is pending with ack low.
    ack_en = 1'b0;
    snap_a = wr_cnt;
    access(1, 0, 8'h3C);
    check_eq("mid_req", vram_req, 1);
    cycle(1);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    check_eq("mid_req_drop", vram_req, 0);
    ack_en = 1'b1;
    cycle(3);
    check_eq("mid_no_write", wr_cnt - snap_a, 0);
    check_reset_outputs("rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
